// File: rtl/agg_4n.sv
// agg_4n: neighbour aggregation of a captured 4-node x 4-feature block.
// Ports: clk, rst (async active-high); mac_ready/mac_out/adj in; agg_ack in; busy/agg_valid/agg_out out.
// Latency: trigger cycle T -> rows written T+1..T+4 -> agg_valid from T+5; result held until agg_ack.
// Optional ReLU on stored sums via macro AGG_RELU_EN (undefined: raw signed sum).
module agg_4n #(
    parameter int AGG_IN_SIZE  = 13,
    parameter int AGG_OUT_SIZE = AGG_IN_SIZE + 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  mac_ready,
    input  logic [3:0][3:0][AGG_IN_SIZE-1:0]      mac_out,
    input  logic [15:0]                           adj,
    input  logic                                  agg_ack,
    output logic                                  busy,
    output logic                                  agg_valid,
    output logic [3:0][3:0][AGG_OUT_SIZE-1:0]     agg_out
);

    localparam int EXT = AGG_OUT_SIZE - AGG_IN_SIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                                state_q, state_d;
    logic [1:0]                            n_q, n_d;
    logic                                  prev_q;
    logic [3:0][3:0][AGG_IN_SIZE-1:0]      h_q, h_d;
    logic [15:0]                           adj_q, adj_d;
    logic [3:0][3:0][AGG_OUT_SIZE-1:0]     agg_q, agg_d;

    logic                                  trigger;
    logic [3:0]                            row_bits;
    logic [3:0][AGG_OUT_SIZE-1:0]          row_val;
    logic signed [AGG_OUT_SIZE-1:0]        acc;
    logic signed [AGG_OUT_SIZE-1:0]        term;

    // Edge on mac_ready; prev_q tracks every cycle so an edge seen outside IDLE is consumed.
    assign trigger  = mac_ready & ~prev_q;
    assign row_bits = adj_q[{n_q, 2'b00} +: 4];

    // Sum of the captured features selected by the current destination row.
    always_comb begin
        row_val = '0;
        acc     = '0;
        term    = '0;
        for (int f = 0; f < 4; f++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) begin
                term = {{EXT{h_q[j][f][AGG_IN_SIZE-1]}}, h_q[j][f]};
                if (row_bits[j]) begin
                    acc = acc + term;
                end
            end
`ifdef AGG_RELU_EN
            row_val[f] = acc[AGG_OUT_SIZE-1] ? '0 : acc;
`else
            row_val[f] = acc;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        h_d     = h_q;
        adj_d   = adj_q;
        agg_d   = agg_q;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    h_d     = mac_out;
                    adj_d   = adj;
                    n_d     = 2'd0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                agg_d[n_q] = row_val;
                n_d        = n_q + 2'd1;
                if (n_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (agg_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= 2'd0;
            prev_q  <= 1'b0;
            h_q     <= '0;
            adj_q   <= '0;
            agg_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            prev_q  <= mac_ready;
            h_q     <= h_d;
            adj_q   <= adj_d;
            agg_q   <= agg_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign agg_valid = (state_q == DONE);
    assign agg_out   = agg_q;

endmodule

// File: tb/tb_agg_4n.sv
module tb_agg_4n;

    localparam int IN  = 13;
    localparam int OUT = 15;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         mac_ready;
    logic [3:0][3:0][IN-1:0]      mac_out;
    logic [15:0]                  adj;
    logic                         agg_ack;
    logic                         busy;
    logic                         agg_valid;
    logic [3:0][3:0][OUT-1:0]     agg_out;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    agg_4n #(.AGG_IN_SIZE(IN), .AGG_OUT_SIZE(OUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .mac_ready (mac_ready),
        .mac_out   (mac_out),
        .adj       (adj),
        .agg_ack   (agg_ack),
        .busy      (busy),
        .agg_valid (agg_valid),
        .agg_out   (agg_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_h_const(input int v);
        for (int j = 0; j < 4; j++)
            for (int f = 0; f < 4; f++)
                mac_out[j][f] = IN'(v);
    endtask

    task automatic set_h_pattern(input int base);
        for (int j = 0; j < 4; j++)
            for (int f = 0; f < 4; f++)
                mac_out[j][f] = IN'(base + 10 * j + f);
    endtask

    // Single-cycle trigger pulse; returns just after the capture edge.
    task automatic pulse();
        mac_ready = 1'b1;
        tick();
        mac_ready = 1'b0;
    endtask

    // Bounded wait for agg_valid; cycles = edges waited (limit+1 if never seen).
    task automatic wait_valid(input int limit, output int cycles);
        cycles = 0;
        while (agg_valid !== 1'b1 && cycles <= limit) begin
            tick();
            cycles++;
        end
    endtask

    task automatic do_ack();
        agg_ack = 1'b1;
        tick();
        agg_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mac_ready = 1'b0; agg_ack = 1'b0; adj = '0;
        set_h_const(0);
        repeat (2) tick();
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else pass_cnt++;
        chk_cnt++; if (agg_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", agg_valid); else pass_cnt++;
        chk_cnt++; if (agg_out !== '0) $display("FAIL rst_agg_out got=%h exp=0", agg_out); else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        tick();
        // reset during ACCUM (row 0 already written with 20)
        set_h_const(5); adj = 16'hFFFF;
        pulse();
        tick();
        chk_cnt++; if (busy !== 1'b1) $display("FAIL mid_accum_busy got=%b exp=1", busy); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else pass_cnt++;
        chk_cnt++; if (agg_valid !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", agg_valid); else pass_cnt++;
        chk_cnt++; if (agg_out !== '0) $display("FAIL midrst_agg_out got=%h exp=0", agg_out); else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        repeat (2) tick();
        chk_cnt++; if (busy !== 1'b0) $display("FAIL postrst_idle got=%b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_identity();
        logic [OUT-1:0] e;
        adj = 16'h8421;
        set_h_pattern(0);
        pulse();
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk_cnt++; if (agg_valid !== 1'b0) $display("FAIL id_early_valid k=%0d got=%b exp=0", k, agg_valid); else pass_cnt++;
        end
        tick();
        chk_cnt++; if (agg_valid !== 1'b1) $display("FAIL id_valid_T5 got=%b exp=1", agg_valid); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL id_busy_done got=%b exp=1", busy); else pass_cnt++;
        for (int i = 0; i < 4; i++)
            for (int f = 0; f < 4; f++) begin
                e = OUT'(10 * i + f);
                chk_cnt++;
                if (agg_out[i][f] !== e) $display("FAIL id_out[%0d][%0d] got=%0d exp=%0d", i, f, agg_out[i][f], e);
                else pass_cnt++;
            end
        repeat (3) tick();
        chk_cnt++; if (agg_valid !== 1'b1) $display("FAIL id_hold_valid got=%b exp=1", agg_valid); else pass_cnt++;
        chk_cnt++; if (agg_out[3][3] !== OUT'(33)) $display("FAIL id_hold_out got=%0d exp=33", agg_out[3][3]); else pass_cnt++;
        do_ack();
        chk_cnt++; if (agg_valid !== 1'b0) $display("FAIL id_ack_valid got=%b exp=0", agg_valid); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL id_ack_busy got=%b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_full();
        int cyc;
        logic [OUT-1:0] e;
        adj = 16'hFFFF;
        set_h_const(4095);
        pulse();
        wait_valid(10, cyc);
        chk_cnt++; if (cyc !== 4) $display("FAIL full_max_latency got=%0d exp=4", cyc); else pass_cnt++;
        e = OUT'(16380);
        for (int i = 0; i < 4; i++)
            for (int f = 0; f < 4; f++) begin
                chk_cnt++;
                if (agg_out[i][f] !== e) $display("FAIL full_max[%0d][%0d] got=%h exp=%h", i, f, agg_out[i][f], e);
                else pass_cnt++;
            end
        do_ack();
        set_h_const(-4096);
        pulse();
        wait_valid(10, cyc);
        chk_cnt++; if (cyc !== 4) $display("FAIL full_min_latency got=%0d exp=4", cyc); else pass_cnt++;
`ifdef AGG_RELU_EN
        e = '0;
`else
        e = OUT'(-16384);
`endif
        for (int i = 0; i < 4; i++)
            for (int f = 0; f < 4; f++) begin
                chk_cnt++;
                if (agg_out[i][f] !== e) $display("FAIL full_min[%0d][%0d] got=%h exp=%h", i, f, agg_out[i][f], e);
                else pass_cnt++;
            end
        do_ack();
    endtask

    task automatic test_empty_row();
        int cyc;
        logic [OUT-1:0] e;
        adj = 16'hF0FF;
        set_h_const(1);
        pulse();
        wait_valid(10, cyc);
        chk_cnt++; if (cyc !== 4) $display("FAIL empty_latency got=%0d exp=4", cyc); else pass_cnt++;
        for (int i = 0; i < 4; i++)
            for (int f = 0; f < 4; f++) begin
                e = (i == 2) ? OUT'(0) : OUT'(4);
                chk_cnt++;
                if (agg_out[i][f] !== e) $display("FAIL empty[%0d][%0d] got=%0d exp=%0d", i, f, agg_out[i][f], e);
                else pass_cnt++;
            end
        do_ack();
    endtask

    task automatic test_level_hold();
        int cyc;
        int busy_seen;
        adj = 16'hFFFF;
        set_h_const(1);
        mac_ready = 1'b1;
        tick();
        wait_valid(10, cyc);
        chk_cnt++; if (cyc !== 4) $display("FAIL level_latency got=%0d exp=4", cyc); else pass_cnt++;
        chk_cnt++; if (agg_out[0][0] !== OUT'(4)) $display("FAIL level_out got=%0d exp=4", agg_out[0][0]); else pass_cnt++;
        do_ack();
        busy_seen = 0;
        repeat (14) begin
            tick();
            if (busy === 1'b1) busy_seen++;
        end
        chk_cnt++; if (busy_seen !== 0) $display("FAIL level_retrigger busy_cycles=%0d exp=0", busy_seen); else pass_cnt++;
        mac_ready = 1'b0;
        tick();
        // second pulse during ACCUM must be ignored and not queued
        set_h_const(1);
        pulse();
        tick();
        set_h_const(2);
        pulse();
        wait_valid(10, cyc);
        chk_cnt++; if (cyc !== 2) $display("FAIL ignore_latency got=%0d exp=2", cyc); else pass_cnt++;
        chk_cnt++; if (agg_out[1][2] !== OUT'(4)) $display("FAIL ignore_out got=%0d exp=4", agg_out[1][2]); else pass_cnt++;
        do_ack();
        tick();
        chk_cnt++; if (busy !== 1'b0) $display("FAIL ignore_not_queued got=%b exp=0", busy); else pass_cnt++;
        set_h_const(3);
        pulse();
        wait_valid(10, cyc);
        chk_cnt++; if (agg_out[3][1] !== OUT'(12)) $display("FAIL repulse_out got=%0d exp=12", agg_out[3][1]); else pass_cnt++;
        do_ack();
    endtask

    task automatic test_isolation();
        int cyc;
        int bad;
        logic [OUT-1:0] e;
        adj = 16'h8421;
        set_h_pattern(100);
        pulse();
        set_h_const(-1);
        adj = 16'hFFFF;
        agg_ack = 1'b1;  // ack outside DONE has no effect
        tick();
        agg_ack = 1'b0;
        wait_valid(10, cyc);
        chk_cnt++; if (cyc !== 3) $display("FAIL iso_latency got=%0d exp=3", cyc); else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 4; i++)
            for (int f = 0; f < 4; f++)
                if (agg_out[i][f] !== OUT'(100 + 10 * i + f)) bad++;
        chk_cnt++; if (bad !== 0) $display("FAIL iso_captured bad_elems=%0d exp=0", bad); else pass_cnt++;
        bad = 0;
        repeat (10) begin
            tick();
            if (agg_valid !== 1'b1) bad++;
            for (int i = 0; i < 4; i++)
                for (int f = 0; f < 4; f++) begin
                    e = OUT'(100 + 10 * i + f);
                    if (agg_out[i][f] !== e) bad++;
                end
        end
        chk_cnt++; if (bad !== 0) $display("FAIL iso_hold_stable bad=%0d exp=0", bad); else pass_cnt++;
        do_ack();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bad;
        adj = 16'h8421;
        set_h_pattern(0);
        pulse();
        wait_valid(10, cyc);
        chk_cnt++; if (cyc !== 4) $display("FAIL b2b_first_latency got=%0d exp=4", cyc); else pass_cnt++;
        agg_ack = 1'b1;  // ack in the first DONE cycle
        tick();
        agg_ack = 1'b0;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL b2b_idle got=%b exp=0", busy); else pass_cnt++;
        set_h_pattern(200);
        pulse();
        chk_cnt++; if (busy !== 1'b1) $display("FAIL b2b_accept got=%b exp=1", busy); else pass_cnt++;
        wait_valid(10, cyc);
        chk_cnt++; if (cyc !== 4) $display("FAIL b2b_second_latency got=%0d exp=4", cyc); else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 4; i++)
            for (int f = 0; f < 4; f++)
                if (agg_out[i][f] !== OUT'(200 + 10 * i + f)) bad++;
        chk_cnt++; if (bad !== 0) $display("FAIL b2b_out bad_elems=%0d exp=0", bad); else pass_cnt++;
        do_ack();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_full();
        test_empty_row();
        test_level_hold();
        test_isolation();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
